// File: rtl/pic_pkg.sv
// Shared constants for the PIC command-word sequencer:
// FSM encoding and command-word bit positions.
package pic_pkg;

  typedef enum logic [1:0] {
    READY     = 2'd0,
    WAIT_ICW2 = 2'd1,
    WAIT_ICW3 = 2'd2,
    WAIT_ICW4 = 2'd3
  } state_t;

  localparam int BIT_D4   = 4;
  localparam int BIT_D3   = 3;
  localparam int BIT_RR   = 1;
  localparam int BIT_RIS  = 0;
  localparam int BIT_P    = 2;
  localparam int BIT_ESMM = 6;
  localparam int BIT_SMM  = 5;

  localparam int BIT_LTIM = 3;
  localparam int BIT_SNGL = 1;
  localparam int BIT_IC4  = 0;

endpackage

// File: rtl/write_edge_detect.sv
// One-cycle pulse on each rising edge of a level strobe;
// a held strobe yields a single pulse.
module write_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/icw_sequencer.sv
// ICW1..ICW4 initialisation sequencer with OCW1..OCW3
// decode for an 8259-style interrupt controller.
module icw_sequencer
  import pic_pkg::*;
#(
  parameter logic [7:0] RESET_IMR = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_strobe,
  input  logic       a1,
  input  logic [7:0] data_in,
  output logic       init_done,
  output logic       ltim,
  output logic       single,
  output logic       ic4,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_cfg,
  output logic       upm,
  output logic       aeoi,
  output logic       ms,
  output logic       buf_mode,
  output logic       sfnm,
  output logic [7:0] imr,
  output logic       ocw2_pulse,
  output logic [2:0] ocw2_cmd,
  output logic [2:0] ocw2_level,
  output logic       read_isr,
  output logic       poll_pulse,
  output logic       special_mask
);

  state_t state;
  state_t state_nx;
  logic   ev;
  logic   armed;
  logic   ocw_ok;
  logic   icw1;
  logic   icw_wr;
  logic   ocw1;
  logic   ocw2;
  logic   ocw3;

  write_edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (wr_strobe),
    .pulse (ev)
  );

  // armed remembers that an ICW1 has been seen since reset
  assign init_done = armed & (state == READY);
  assign ocw_ok    = init_done;

  assign icw1   = ev & ~a1 & data_in[BIT_D4];
  assign icw_wr = ev & a1 & (state != READY);
  assign ocw1   = ev & a1 & ocw_ok;
  assign ocw2   = ev & ~a1 & ~data_in[BIT_D4]
                & ~data_in[BIT_D3] & ocw_ok;
  assign ocw3   = ev & ~a1 & ~data_in[BIT_D4]
                & data_in[BIT_D3] & ocw_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= READY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (icw1) begin
      state_nx = WAIT_ICW2;
    end else if (icw_wr) begin
      unique case (state)
        WAIT_ICW2: begin
          if (!single)  state_nx = WAIT_ICW3;
          else if (ic4) state_nx = WAIT_ICW4;
          else          state_nx = READY;
        end
        WAIT_ICW3: state_nx = ic4 ? WAIT_ICW4 : READY;
        WAIT_ICW4: state_nx = READY;
        default:   state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed        <= 1'b0;
      ltim         <= 1'b0;
      single       <= 1'b0;
      ic4          <= 1'b0;
      vector_base  <= '0;
      cascade_cfg  <= '0;
      upm          <= 1'b0;
      aeoi         <= 1'b0;
      ms           <= 1'b0;
      buf_mode     <= 1'b0;
      sfnm         <= 1'b0;
      imr          <= RESET_IMR;
      ocw2_pulse   <= 1'b0;
      ocw2_cmd     <= '0;
      ocw2_level   <= '0;
      read_isr     <= 1'b0;
      poll_pulse   <= 1'b0;
      special_mask <= 1'b0;
    end else begin
      ocw2_pulse <= ocw2;
      poll_pulse <= ocw3 & data_in[BIT_P];
      if (icw1) begin
        armed        <= 1'b1;
        ltim         <= data_in[BIT_LTIM];
        single       <= data_in[BIT_SNGL];
        ic4          <= data_in[BIT_IC4];
        imr          <= '0;
        read_isr     <= 1'b0;
        special_mask <= 1'b0;
        upm          <= 1'b0;
        aeoi         <= 1'b0;
        ms           <= 1'b0;
        buf_mode     <= 1'b0;
        sfnm         <= 1'b0;
      end
      if (icw_wr) begin
        unique case (state)
          WAIT_ICW2: vector_base <= data_in[7:3];
          WAIT_ICW3: cascade_cfg <= data_in;
          WAIT_ICW4: begin
            upm      <= data_in[0];
            aeoi     <= data_in[1];
            ms       <= data_in[2];
            buf_mode <= data_in[3];
            sfnm     <= data_in[4];
          end
          default: ;
        endcase
      end
      if (ocw1) imr <= data_in;
      if (ocw2) begin
        ocw2_cmd   <= data_in[7:5];
        ocw2_level <= data_in[2:0];
      end
      if (ocw3) begin
        if (data_in[BIT_RR])   read_isr     <= data_in[BIT_RIS];
        if (data_in[BIT_ESMM]) special_mask <= data_in[BIT_SMM];
      end
    end
  end

endmodule

// File: tb/tb_icw_sequencer.sv
// Scoreboard bench: queue-based reference model of the
// ICW/OCW rules against icw_sequencer, directed plus random.
module tb_icw_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_strobe = 1'b0;
  logic       a1 = 1'b0;
  logic [7:0] data_in = '0;
  logic       init_done, ltim, single, ic4;
  logic [4:0] vector_base;
  logic [7:0] cascade_cfg, imr;
  logic       upm, aeoi, ms, buf_mode, sfnm;
  logic       ocw2_pulse, read_isr, poll_pulse, special_mask;
  logic [2:0] ocw2_cmd, ocw2_level;

  icw_sequencer #(.RESET_IMR(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .wr_strobe(wr_strobe),
    .a1(a1), .data_in(data_in), .init_done(init_done),
    .ltim(ltim), .single(single), .ic4(ic4),
    .vector_base(vector_base), .cascade_cfg(cascade_cfg),
    .upm(upm), .aeoi(aeoi), .ms(ms), .buf_mode(buf_mode),
    .sfnm(sfnm), .imr(imr), .ocw2_pulse(ocw2_pulse),
    .ocw2_cmd(ocw2_cmd), .ocw2_level(ocw2_level),
    .read_isr(read_isr), .poll_pulse(poll_pulse),
    .special_mask(special_mask)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef logic [37:0] snap_t;
  snap_t      snap_q[$];
  logic [5:0] ocw2_q[$];
  bit         poll_q[$];

  // reference model state
  bit         m_inited;
  int         pend[$];
  logic       m_ltim, m_single, m_ic4;
  logic [4:0] m_vb;
  logic [7:0] m_cas, m_imr;
  logic [4:0] m_icw4;
  logic [2:0] m_cmd, m_lvl;
  logic       m_risr, m_sm;

  snap_t dut_snap;
  assign dut_snap = {init_done, ltim, single, ic4, vector_base,
                     cascade_cfg, sfnm, buf_mode, ms, aeoi, upm,
                     imr, ocw2_cmd, ocw2_level, read_isr,
                     special_mask};

  function automatic snap_t m_snap();
    logic done;
    done = m_inited && (pend.size() == 0);
    return {done, m_ltim, m_single, m_ic4, m_vb, m_cas, m_icw4,
            m_imr, m_cmd, m_lvl, m_risr, m_sm};
  endfunction

  task automatic m_reset();
    m_inited = 0; pend.delete();
    m_ltim = 0; m_single = 0; m_ic4 = 0;
    m_vb = '0; m_cas = '0; m_imr = 8'hFF; m_icw4 = '0;
    m_cmd = '0; m_lvl = '0; m_risr = 0; m_sm = 0;
  endtask

  task automatic m_write(input logic a, input logic [7:0] d);
    int k;
    if (!a && d[4]) begin
      m_inited = 1;
      m_ltim = d[3]; m_single = d[1]; m_ic4 = d[0];
      m_imr = '0; m_risr = 0; m_sm = 0; m_icw4 = '0;
      pend.delete();
      pend.push_back(2);
      if (!d[1]) pend.push_back(3);
      if (d[0])  pend.push_back(4);
    end else if (a && pend.size() > 0) begin
      k = pend.pop_front();
      if (k == 2)      m_vb = d[7:3];
      else if (k == 3) m_cas = d;
      else             m_icw4 = d[4:0];
    end else if (m_inited && pend.size() == 0) begin
      if (a) begin
        m_imr = d;
      end else if (!d[3]) begin
        m_cmd = d[7:5]; m_lvl = d[2:0];
        ocw2_q.push_back({d[7:5], d[2:0]});
      end else begin
        if (d[1]) m_risr = d[0];
        if (d[6]) m_sm = d[5];
        if (d[2]) poll_q.push_back(1'b1);
      end
    end
  endtask

  task automatic wr(input logic a, input logic [7:0] d,
                    input int hold);
    @(posedge clk); #1;
    a1 = a; data_in = d; wr_strobe = 1'b1;
    m_write(a, d);
    repeat (hold) @(posedge clk);
    #1 wr_strobe = 1'b0;
    @(posedge clk); #1;
    snap_q.push_back(m_snap());
  endtask

  // monitor: pulses pop their queues, snapshots are compared
  always @(negedge clk) begin
    if (rst_n) begin
      if (ocw2_pulse) begin
        n_chk++;
        if (ocw2_q.size() == 0) begin
          n_fail++;
          $display("FAIL ocw2_pulse: got unexpected pulse, want none");
        end else begin
          logic [5:0] e;
          e = ocw2_q.pop_front();
          if ({ocw2_cmd, ocw2_level} !== e) begin
            n_fail++;
            $display("FAIL ocw2_fields: got %h want %h",
                     {ocw2_cmd, ocw2_level}, e);
          end
        end
      end
      if (poll_pulse) begin
        n_chk++;
        if (poll_q.size() == 0) begin
          n_fail++;
          $display("FAIL poll_pulse: got unexpected pulse, want none");
        end else begin
          void'(poll_q.pop_front());
        end
      end
      if (snap_q.size() > 0) begin
        snap_t e;
        e = snap_q.pop_front();
        n_chk++;
        if (dut_snap !== e) begin
          n_fail++;
          $display("FAIL snapshot: got %h want %h", dut_snap, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ra;
    logic [7:0] rd;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_snap", 32'(dut_snap), 32'(m_snap()));
    chk("reset_hi", 32'(dut_snap >> 32), 32'(m_snap() >> 32));
    chk("reset_pulses", {ocw2_pulse, poll_pulse}, 0);
    rst_n = 1'b1;

    wr(0, 8'h13, 1); wr(1, 8'h08, 1); wr(1, 8'h01, 1);
    @(posedge clk); #1;
    chk("r36_vb", vector_base, 5'h01);
    chk("r36_upm_done", {upm, init_done}, 2'b11);
    chk("r36_cas", cascade_cfg, 8'h00);

    wr(0, 8'h11, 1); wr(1, 8'h20, 2); wr(1, 8'h04, 1);
    wr(1, 8'h03, 1);
    @(posedge clk); #1;
    chk("r37", {cascade_cfg, aeoi, upm, init_done}, {8'h04, 3'b111});

    wr(1, 8'hA5, 1); wr(0, 8'h63, 3);
    wr(0, 8'h0B, 1); wr(0, 8'h0C, 2); wr(0, 8'h68, 1);
    @(posedge clk); #1;
    chk("r38_imr", imr, 8'hA5);
    chk("r39_isr_sm", {read_isr, special_mask}, 2'b11);

    wr(0, 8'h13, 1); wr(0, 8'h12, 1);
    @(posedge clk); #1;
    chk("r40_wait", {init_done, ic4}, 2'b00);
    wr(1, 8'h48, 5);
    wr(0, 8'h21, 5);
    @(posedge clk); #1;
    chk("r40_ready", init_done, 1);

    wr(0, 8'h11, 1); wr(1, 8'h20, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("r41_async", {init_done, imr}, {1'b0, 8'hFF});
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr(1, 8'h55, 1);
    wr(0, 8'h0B, 1);

    for (int i = 0; i < 400; i++) begin
      ra = 1'($urandom_range(0, 1));
      rd = 8'($urandom);
      if (!ra) begin
        if ($urandom_range(0, 9) == 0 || !m_inited) rd[4] = 1'b1;
        else rd[4] = 1'b0;
      end
      wr(ra, rd, $urandom_range(1, 3));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("ocw2_q_empty", ocw2_q.size(), 0);
    chk("poll_q_empty", poll_q.size(), 0);
    chk("snap_q_empty", snap_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/icw_sequencer.md
ICW_SEQUENCER -- requirements
Module: icw_sequencer

Interface
REQ-001 Parameter: RESET_IMR, 8'hFF, IMR value after hardware reset (all IRs masked before init).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 wr_strobe  input  1  bus write active (CS and WR low), level, synchronous to clk.
REQ-005 a1  input  1  address bit selecting command-word port.
REQ-006 data_in  input  8  write data from internal bus.
REQ-007 init_done  output  1  high when ICW sequence is complete and state is READY.
REQ-008 ltim, single, ic4  output  1 each  latched ICW1 D3, D1, D0.
REQ-009 vector_base  output  5  latched ICW2 D7..D3.
REQ-010 cascade_cfg  output  8  latched ICW3.
REQ-011 upm, aeoi, ms, buf_mode, sfnm  output  1 each  latched ICW4 D0..D4.
REQ-012 imr  output  8  interrupt mask register (OCW1).
REQ-013 ocw2_pulse  output  1  one-cycle strobe for an accepted OCW2.
REQ-014 ocw2_cmd  output  3  R, SL, EOI of the last OCW2; ocw2_level output 3, its L2..L0.
REQ-015 read_isr  output  1  register read select: 0 = IRR, 1 = ISR.
REQ-016 poll_pulse  output  1  one-cycle strobe for an OCW3 with P=1.
REQ-017 special_mask  output  1  special mask mode enable.

Function
REQ-018 Write event = rising edge of wr_strobe (registered previous value); a held strobe is one event.
REQ-019 Decode per event: a1=0 & D4=1 -> ICW1; a1=0 & D4=0 & D3=0 -> OCW2; a1=0 & D4=0 & D3=1 -> OCW3; a1=1 -> ICW2/ICW3/ICW4 per state, else OCW1.
REQ-020 States: READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4; state encoding 2 bits.
REQ-021 ICW1 in any state -> WAIT_ICW2; latch ltim/single/ic4; imr<=0; read_isr<=0; special_mask<=0; clear ICW4 fields to 0 (applies when ic4=0); init_done<=0.
REQ-022 WAIT_ICW2 + a1=1 write -> latch vector_base; next WAIT_ICW3 if single=0, else WAIT_ICW4 if ic4=1, else READY.
REQ-023 WAIT_ICW3 + a1=1 write -> latch cascade_cfg; next WAIT_ICW4 if ic4=1, else READY.
REQ-024 WAIT_ICW4 + a1=1 write -> latch upm/aeoi/ms/buf_mode/sfnm; next READY.
REQ-025 init_done is high exactly when state is READY and at least one ICW1 was accepted since reset.
REQ-026 OCW1/OCW2/OCW3 accepted only in READY with init_done=1; a1=0 non-ICW1 writes in WAIT_* states are ignored.
REQ-027 OCW1: imr<=data_in, visible the cycle after the edge is detected.
REQ-028 OCW2: ocw2_cmd<=D7..D5, ocw2_level<=D2..D0, ocw2_pulse high exactly one cycle.
REQ-029 OCW3: if D1(RR)=1, read_isr<=D0; if D6(ESMM)=1, special_mask<=D5; if D2=1, poll_pulse high exactly one cycle; otherwise fields unchanged.
REQ-030 Latency: from clk edge sampling wr_strobe 0->1 to updated output is 1 cycle; pulses last 1 cycle and never repeat without a new edge.
REQ-031 ICW1 arriving mid-sequence restarts the sequence; previously latched ICW2-4 values remain until overwritten.

Reset
REQ-032 rst_n low asynchronously forces: state READY, init_done 0, imr RESET_IMR, all ICW fields 0, ocw2_cmd/level 0, pulses 0, read_isr 0, special_mask 0, edge register 0.
REQ-033 Reset asserted mid-sequence abandons it; a new ICW1 is required.

Structure
REQ-034 State encoding and ICW/OCW decode bit positions (D4, D3, RR, RIS, P, ESMM, SMM) shall be constants in a shared pic_pkg package.
REQ-035 One sub-module, write_edge_detect (rising-edge pulse generator), shall be instantiated; the FSM and registers stay in icw_sequencer.

Verification
REQ-036 Reset, then ICW1=8'h13 (single, ic4), ICW2=8'h08 a1=1, ICW4=8'h01 -> vector_base 5'h01, upm 1, init_done 1, cascade_cfg 0.
REQ-037 ICW1=8'h11 (cascade, ic4), ICW2=8'h20, ICW3=8'h04, ICW4=8'h03 -> cascade_cfg 8'h04, aeoi 1, upm 1, init_done 1.
REQ-038 After init, OCW1=8'hA5 -> imr 8'hA5; OCW2=8'h63 -> ocw2_pulse 1 cycle, ocw2_cmd 3'b011, ocw2_level 3'b011.
REQ-039 OCW3=8'h0B -> read_isr 1; OCW3=8'h0C -> poll_pulse 1 cycle, read_isr stays 1; OCW3=8'h68 -> special_mask 1.
REQ-040 ICW1=8'h13 then ICW1=8'h12 before ICW2 -> state WAIT_ICW2, ic4 0; ICW2 -> READY without ICW4; wr_strobe held 5 cycles gives a single event.
REQ-041 rst_n pulled low in WAIT_ICW3 -> immediate init_done 0, imr 8'hFF; a1=1 write afterwards is ignored until ICW1.
